// File: rtl/scalar_wb_scheduler.sv
// Writeback scheduler for a single-write-port scalar register file: arbitrates loads against ALU
// results through a 2-entry skid FIFO and keeps a pending-write scoreboard that drives the decode stall.
module scalar_wb_scheduler #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        iss_valid,
   input  logic [ADDR_W-1:0]           iss_dst,
   input  logic [ADDR_W-1:0]           iss_src1,
   input  logic [ADDR_W-1:0]           iss_src2,
   input  logic                        iss_src1_used,
   input  logic                        iss_src2_used,
   output logic                        stall,
   input  logic                        alu_valid,
   input  logic [ADDR_W-1:0]           alu_dst,
   input  logic [DATA_W-1:0]           alu_data,
   output logic                        alu_ready,
   input  logic                        ld_valid,
   input  logic [ADDR_W-1:0]           ld_dst,
   input  logic [DATA_W-1:0]           ld_data,
   output logic                        rf_wr_en,
   output logic [ADDR_W-1:0]           rf_wr_dst,
   output logic [DATA_W-1:0]           rf_wr_data,
   output logic [(1<<ADDR_W)-1:0]      pending,
   output logic [1:0]                  buf_count,
   output logic                        wb_err
);

   localparam int NREG = 1 << ADDR_W;

   logic [ADDR_W-1:0] q_dst  [2];
   logic [DATA_W-1:0] q_data [2];

   logic              alu_acc;
   logic              iss_acc;
   logic              fifo_pop;
   logic              fifo_push;
   logic              push_slot;
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_dst_d;
   logic [DATA_W-1:0] wr_data_d;
   logic [NREG-1:0]   set_mask;
   logic [NREG-1:0]   clr_mask;
   logic              err_d;

   assign alu_ready = (buf_count != 2'd2);
   assign alu_acc   = alu_valid & alu_ready;
   assign stall     = iss_valid & ((iss_src1_used & pending[iss_src1]) |
                                   (iss_src2_used & pending[iss_src2]) |
                                   pending[iss_dst]);
   assign iss_acc   = iss_valid & ~stall;

   // A load always owns the port; the FIFO head beats a fresh ALU result to keep program order.
   assign fifo_pop  = ~ld_valid & (buf_count != 2'd0);
   assign fifo_push = alu_acc & (ld_valid | (buf_count != 2'd0));
   assign push_slot = fifo_pop ? 1'b0 : buf_count[0];

   always_comb begin
      wr_en_d   = 1'b0;
      wr_dst_d  = rf_wr_dst;
      wr_data_d = rf_wr_data;
      if (ld_valid) begin
         wr_en_d   = 1'b1;
         wr_dst_d  = ld_dst;
         wr_data_d = ld_data;
      end else if (buf_count != 2'd0) begin
         wr_en_d   = 1'b1;
         wr_dst_d  = q_dst[0];
         wr_data_d = q_data[0];
      end else if (alu_acc) begin
         wr_en_d   = 1'b1;
         wr_dst_d  = alu_dst;
         wr_data_d = alu_data;
      end
   end

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (iss_acc)  set_mask = NREG'(1) << iss_dst;
      if (rf_wr_en) clr_mask = NREG'(1) << rf_wr_dst;
   end

   // The ALU result also counts as unexpected when a same-cycle load consumes the same pending bit.
   assign err_d = (ld_valid & ~pending[ld_dst]) |
                  (alu_acc & (~pending[alu_dst] | (ld_valid & (ld_dst == alu_dst))));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending    <= '0;
         buf_count  <= 2'd0;
         rf_wr_en   <= 1'b0;
         rf_wr_dst  <= '0;
         rf_wr_data <= '0;
         wb_err     <= 1'b0;
         q_dst[0]   <= '0;
         q_dst[1]   <= '0;
         q_data[0]  <= '0;
         q_data[1]  <= '0;
      end else begin
         pending    <= (pending & ~clr_mask) | set_mask;
         rf_wr_en   <= wr_en_d;
         rf_wr_dst  <= wr_dst_d;
         rf_wr_data <= wr_data_d;
         if (err_d) wb_err <= 1'b1;
         if (fifo_pop) begin
            q_dst[0]  <= q_dst[1];
            q_data[0] <= q_data[1];
         end
         if (fifo_push) begin
            q_dst[push_slot]  <= alu_dst;
            q_data[push_slot] <= alu_data;
         end
         buf_count <= buf_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
      end
   end

endmodule

// File: doc/scalar_wb_scheduler.md
# scalar_wb_scheduler

Writeback scheduler and scoreboard for the 8-entry, 16-bit scalar register file, which has one write port. It shares the write port between the ALU result path and the load-return path, buffering ALU results when a load wins. It also tracks which registers have writes in flight and stalls decode on read-after-write and write-after-write hazards. It sits between the decode/execute/memory stages and the register file's write port.

## Interface
- DATA_W, 16: register data width
- ADDR_W, 3: register address width; the register count is 2^ADDR_W = 8
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  decode presents an instruction that writes iss_dst
- iss_dst  in  ADDR_W  destination of the issuing instruction
- iss_src1, iss_src2  in  ADDR_W  source registers of the issuing instruction
- iss_src1_used, iss_src2_used  in  1  the matching source is actually read
- stall  out  1  decode must hold; the issue is not accepted this cycle
- alu_valid  in  1  ALU result available
- alu_dst  in  ADDR_W  ALU result destination
- alu_data  in  DATA_W  ALU result value
- alu_ready  out  1  ALU result is accepted this cycle when alu_valid=1
- ld_valid  in  1  load return available; always accepted, never back-pressured
- ld_dst  in  ADDR_W  load destination
- ld_data  in  DATA_W  load return value
- rf_wr_en  out  1  register file write enable (registered)
- rf_wr_dst  out  ADDR_W  register file write address (registered)
- rf_wr_data  out  DATA_W  register file write data (registered)
- pending  out  8  scoreboard; bit r=1 means a write to register r is in flight
- buf_count  out  2  occupancy of the ALU skid FIFO, 0..2
- wb_err  out  1  sticky flag: a writeback arrived for a non-pending register

## Operation
- **Scoreboard**
  - An issue is accepted when iss_valid=1 and stall=0; acceptance sets pending[iss_dst].
  - A write clears pending[rf_wr_dst] at the edge that ends a cycle with rf_wr_en=1.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- **Stall rule:** stall = iss_valid & ((iss_src1_used & pending[src1]) | (iss_src2_used & pending[src2]) | pending[iss_dst]).
- **ALU skid FIFO:** 2 entries of {dst, data}, in-order. alu_ready = (buf_count < 2).
- **Write-port arbitration each cycle, strict priority:**
  1. ld_valid: the load wins.
  2. Otherwise, if the FIFO is non-empty: pop the head and write it.
  3. Otherwise, if alu_valid: bypass the ALU result directly to the write port.
  4. Otherwise: no write next cycle (rf_wr_en=0; rf_wr_dst and rf_wr_data hold their last values).
- **Accepted ALU results that do not win** (because of a load, or a non-empty FIFO) are pushed into the FIFO. This preserves ALU program order.
- **FIFO push and pop in the same cycle:** buf_count is unchanged.
- **wb_err** is set when an accepted load, or an accepted ALU result, targets a register whose pending bit is 0 at acceptance. Only reset clears it.
- **Same-cycle ld and ALU to the same dst** is prevented by the WAW stall. If it occurs anyway, both writes are performed (load first, then ALU) and the ALU result sets wb_err.
- **Reset (asynchronous, any time):**
  - pending=0, FIFO emptied (buf_count=0), alu_ready=1.
  - rf_wr_en=0, rf_wr_dst=0, rf_wr_data=0, wb_err=0.
  - Buffered results are discarded.

## Timing
- stall and alu_ready are combinational. stall depends on current inputs and pending; alu_ready depends on buf_count only, never on alu_valid.
- Load accepted in cycle N: rf_wr_* is valid in cycle N+1, and pending clears at the end of N+1. A dependent instruction issues no earlier than cycle N+2.
- ALU bypass has the same one-cycle latency. A buffered ALU result is written one cycle after the cycle it reaches the FIFO head with no competing load.
- Throughput is one register write per cycle. A continuous load stream starves the FIFO; the ALU then stalls via alu_ready=0 once 2 entries are held.

## Test plan
- Reset, then issue dst=3 and return ld 3/0xBEEF → pending=0x08 after the issue edge; rf_wr_en=1, dst=3, data=0xBEEF one cycle after ld; pending=0x00 afterward.
- Issue dst=2, then an instruction with iss_src1=2 used → stall=1 until rf_wr_en for r2 completes; it issues in the following cycle. With src1_used=0 there is no stall; with dst=2 (WAW) it stalls.
- Same cycle: ld 1/0x1111 and ALU 4/0x4444 → write r1 in cycle N+1 and r4 in N+2; buf_count=1 during N+1.
- Four back-to-back loads while the ALU presents 3 results → buf_count reaches 2, alu_ready=0, the third ALU result is held by the producer; after the loads end, the ALU results are written in order.
- ALU writeback to r5 with pending[5]=0 → wb_err=1, the write is still performed, and wb_err stays 1 until rst.
- Assert rst while buf_count=2 and pending=0xFF → everything returns to reset values immediately, without waiting for a clock; no rf_wr_en pulse follows.
